spi_accel_responder: RTL and testbench
======================================

SPI_ACCEL_RESPONDER -- requirements
Module: spi_accel_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for SCLK/CS/MOSI.
REQ-002 SHALL have port CLK  input  1  system clock, 125 MHz; the only clock.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port CS  input  1  SPI chip select, active low, asynchronous to CLK.
REQ-005 SHALL have port SCLK  input  1  SPI clock, mode 0, at most CLK/16.
REQ-006 SHALL have port MOSI  input  1  serial data from the controller, MSB first.
REQ-007 SHALL have port MISO  output  1  serial data to the controller, MSB first.
REQ-008 SHALL have ports SAMPLE_X, SAMPLE_Y, SAMPLE_Z  input  8 each  new axis samples.
REQ-009 SHALL have port SAMPLE_VALID  input  1  one-CLK strobe that qualifies the SAMPLE_* inputs.
REQ-010 SHALL have port CFG_WR  output  1  one-CLK pulse per committed register write.
REQ-011 SHALL have ports CFG_ADDR  output  6  and  CFG_DATA  output  8  giving the address and data of the last write.
REQ-012 SHALL have port MEASURE_EN  output  1  high while reg 0x2D[1:0] == 2'b10.

Function
REQ-013 SHALL pass CS, SCLK and MOSI through SYNC_STAGES flops, then derive single-CLK rise and fall strobes; the latency from pin edge to strobe SHALL be SYNC_STAGES+1 CLK.
REQ-014 SHALL hold a 64x8 register file: 0x00=0xAD, 0x01=0x1D, 0x02=0xF2, 0x03=0x01, 0x09=X, 0x0A=Y, 0x0B=Z; all other addresses reset to 0x00.
REQ-015 SHALL treat 0x00-0x1F as read-only and 0x20-0x3F as writable.
REQ-016 SHALL implement FSM states IDLE, CMD, ADDR, RD_DATA, WR_DATA and IGNORE.
REQ-017 Transitions SHALL be:
- IDLE->CMD on a synced CS fall, with the bit counter cleared.
- CMD->ADDR after 8 SCLK rises.
- ADDR->RD_DATA if the opcode is 0x0B.
- ADDR->WR_DATA if the opcode is 0x0A.
- CMD->IGNORE on any other opcode.
- Any state->IDLE on a synced CS rise.
REQ-018 SHALL sample MOSI on each synced SCLK rise into an 8-bit shift register.
REQ-019 Read: after the 8th address bit, SHALL load reg[addr] into the TX shifter; MISO SHALL present the MSB after the next synced SCLK fall and shift on each subsequent fall.
REQ-020 Write: on the 8th data bit, SHALL write reg[addr] if addr is in 0x20-0x3F, pulse CFG_WR for 1 CLK with CFG_ADDR/CFG_DATA, and write one CLK after the rise strobe.
REQ-021 Burst: after each completed data byte, addr SHALL increment. Reads SHALL reload the TX shifter from the new addr. This SHALL continue until CS rises.
REQ-022 Addr 0x3F SHALL increment to 0x40. Reads at >=0x40 SHALL return 0x00; writes at >=0x40, or to read-only addresses, SHALL be dropped with no CFG_WR.
REQ-023 MISO SHALL be 0 in IDLE, CMD, ADDR, WR_DATA and IGNORE.
REQ-024 A CS rise mid-byte SHALL discard the partial byte: no write and no CFG_WR.
REQ-025 When SAMPLE_VALID is high and CS is high (synced), SHALL update 0x09-0x0B in the same CLK.
REQ-026 When SAMPLE_VALID is high while CS is low, SHALL hold the sample in a one-deep shadow and commit it 1 CLK after the CS rise strobe. A newer SAMPLE_VALID SHALL overwrite the shadow.
REQ-027 MEASURE_EN SHALL update the CLK after a write to 0x2D.

Reset
REQ-028 RESET SHALL force: FSM=IDLE, MISO=0, CFG_WR=0, CFG_ADDR=0, CFG_DATA=0, MEASURE_EN=0, the register file to REQ-014 values, the shadow empty, and synchronizer flops to CS=1, SCLK=0.
REQ-029 After RESET, SHALL leave IDLE only on a CS fall seen after CS was observed high, so a transaction in progress during reset is ignored.

Structure
REQ-030 The shared package SHALL hold the opcodes 0x0A/0x0B, the register addresses (DEVID 0x00, XDATA 0x09-ZDATA 0x0B, POWER_CTL 0x2D), the reset values, the writable range and the FSM state encodings.
REQ-031 SHALL instantiate one sub-module, spi_sync_edge (synchronizer plus rise/fall strobe), three times.

Verification
REQ-032 Read DEVID: CS low, shift 0x0B 0x00 then 8 clocks -> MISO byte 0xAD.
REQ-033 Burst read 0x00: shift 0x0B 0x00 then 32 clocks -> 0xAD, 0x1D, 0xF2, 0x01.
REQ-034 Setup write 0x0A 0x2D 0x0A -> CFG_WR=1 for 1 CLK, CFG_ADDR=0x2D, CFG_DATA=0x0A, MEASURE_EN=1; a read of 0x2D then returns 0x0A.
REQ-035 Write 0x0A 0x05 0x55 -> no CFG_WR; a read of 0x05 still returns 0x00.
REQ-036 SAMPLE_VALID with X=0x12 during a burst read of 0x09 -> the burst returns the old value; after the CS rise, a read of 0x09 returns 0x12.
REQ-037 CS rise after 4 data bits of a write to 0x20 -> reg 0x20 stays 0x00, no CFG_WR; RESET pulsed mid-read -> MISO=0 until CS is cycled.

Source files
------------

// File: rtl/spi_accel_responder_pkg.sv
// Shared constants for the SPI accelerometer responder: opcodes, register map,
// reset values, writable window and FSM state encodings.
package spi_accel_responder_pkg;

    localparam logic [7:0] OP_WRITE = 8'h0A;
    localparam logic [7:0] OP_READ  = 8'h0B;

    localparam logic [5:0] ADDR_DEVID     = 6'h00;
    localparam logic [5:0] ADDR_XDATA     = 6'h09;
    localparam logic [5:0] ADDR_YDATA     = 6'h0A;
    localparam logic [5:0] ADDR_ZDATA     = 6'h0B;
    localparam logic [5:0] ADDR_POWER_CTL = 6'h2D;

    localparam logic [5:0] WR_LO = 6'h20;
    localparam logic [5:0] WR_HI = 6'h3F;

    // One past the register file; burst addresses park here.
    localparam logic [6:0] ADDR_END = 7'h40;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_IGNORE  = 3'd5
    } state_t;

    function automatic logic [7:0] reg_reset_value(input logic [5:0] a);
        case (a)
            6'h00:   return 8'hAD;
            6'h01:   return 8'h1D;
            6'h02:   return 8'hF2;
            6'h03:   return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic is_writable(input logic [6:0] a);
        return (a >= {1'b0, WR_LO}) && (a <= {1'b0, WR_HI});
    endfunction

    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        return (a >= ADDR_END) ? ADDR_END : a + 7'd1;
    endfunction

endpackage

// File: rtl/spi_accel_responder_spi_sync_edge.sv
// Synchronizes one asynchronous pin into CLK and emits registered rise/fall strobes.
// Pin edge to strobe is STAGES+1 clocks; level is aligned with the strobes.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            level  <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            level <= sync_q[STAGES-1];
            rise  <= sync_q[STAGES-1] & ~level;
            fall  <= ~sync_q[STAGES-1] & level;
        end
    end

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 responder emulating a small accelerometer register file with burst
// read/write, live axis samples and a config-write side channel.
module spi_accel_responder
    import spi_accel_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [7:0] SAMPLE_X,
    input  logic [7:0] SAMPLE_Y,
    input  logic [7:0] SAMPLE_Z,
    input  logic       SAMPLE_VALID,
    output logic       CFG_WR,
    output logic [5:0] CFG_ADDR,
    output logic [7:0] CFG_DATA,
    output logic       MEASURE_EN
);

    localparam int SETTLE = SYNC_STAGES + 1;

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic sync_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(CLK), .reset(RESET), .din(CS),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(CLK), .reset(RESET), .din(SCLK),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(CLK), .reset(RESET), .din(MOSI),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign sync_unused = &{sclk_lvl, mosi_rise, mosi_fall};

    state_t      state, state_next;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  opcode;
    logic [6:0]  addr;
    logic [7:0]  tx;
    logic        miso_q;
    logic [7:0]  regs [64];
    logic        shadow_vld;
    logic [7:0]  shadow_x, shadow_y, shadow_z;
    logic        commit_pend;
    logic        armed;
    logic [7:0]  settle_cnt;

    logic [7:0]  rx_byte;
    logic        byte_done;
    logic [6:0]  addr_load;
    logic [7:0]  rd_val;

    assign rx_byte   = {shift[6:0], mosi_lvl};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !cs_rise && (state != ST_IDLE);

    // Address the TX shifter loads from: the received address byte, or the next burst address.
    always_comb begin
        addr_load = addr_inc(addr);
        if (state == ST_ADDR) begin
            addr_load = (rx_byte[7:6] != 2'b00) ? ADDR_END : {1'b0, rx_byte[5:0]};
        end
        rd_val = addr_load[6] ? 8'h00 : regs[addr_load[5:0]];
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cs_rise) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cs_fall && armed) state_next = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        state_next = (rx_byte == OP_READ || rx_byte == OP_WRITE) ? ST_ADDR : ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        state_next = (opcode == OP_READ) ? ST_RD_DATA : ST_WR_DATA;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_cnt     <= 3'd0;
            shift       <= 8'h00;
            opcode      <= 8'h00;
            addr        <= 7'd0;
            tx          <= 8'h00;
            miso_q      <= 1'b0;
            shadow_vld  <= 1'b0;
            shadow_x    <= 8'h00;
            shadow_y    <= 8'h00;
            shadow_z    <= 8'h00;
            commit_pend <= 1'b0;
            armed       <= 1'b0;
            settle_cnt  <= 8'd0;
            CFG_WR      <= 1'b0;
            CFG_ADDR    <= 6'd0;
            CFG_DATA    <= 8'h00;
            MEASURE_EN  <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                regs[i] <= reg_reset_value(i[5:0]);
            end
        end else begin
            CFG_WR <= 1'b0;

            // The synced CS level is only trusted once the reset value has flushed out,
            // so a transaction already running at reset release is never joined.
            if (settle_cnt != SETTLE[7:0]) settle_cnt <= settle_cnt + 8'd1;
            else if (cs_lvl)               armed      <= 1'b1;

            if (state == ST_IDLE && state_next == ST_CMD) begin
                bit_cnt <= 3'd0;
                shift   <= 8'h00;
            end else if (sclk_rise && state != ST_IDLE) begin
                shift   <= rx_byte;
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (state == ST_CMD && byte_done) opcode <= rx_byte;

            if (state == ST_RD_DATA && sclk_fall) begin
                miso_q <= tx[7];
                tx     <= {tx[6:0], 1'b0};
            end else if (state != ST_RD_DATA) begin
                miso_q <= 1'b0;
            end

            if (byte_done && (state == ST_ADDR || state == ST_RD_DATA)) begin
                addr <= addr_load;
                tx   <= rd_val;
            end

            if (byte_done && state == ST_WR_DATA) begin
                addr <= addr_inc(addr);
                if (is_writable(addr)) begin
                    regs[addr[5:0]] <= rx_byte;
                    CFG_WR          <= 1'b1;
                    CFG_ADDR        <= addr[5:0];
                    CFG_DATA        <= rx_byte;
                end
            end

            // Samples arriving mid-transaction wait in the shadow so bursts see a stable snapshot.
            commit_pend <= cs_rise;
            if (SAMPLE_VALID && cs_lvl) begin
                regs[ADDR_XDATA] <= SAMPLE_X;
                regs[ADDR_YDATA] <= SAMPLE_Y;
                regs[ADDR_ZDATA] <= SAMPLE_Z;
                shadow_vld       <= 1'b0;
            end else if (SAMPLE_VALID) begin
                shadow_x   <= SAMPLE_X;
                shadow_y   <= SAMPLE_Y;
                shadow_z   <= SAMPLE_Z;
                shadow_vld <= 1'b1;
            end else if (commit_pend && shadow_vld) begin
                regs[ADDR_XDATA] <= shadow_x;
                regs[ADDR_YDATA] <= shadow_y;
                regs[ADDR_ZDATA] <= shadow_z;
                shadow_vld       <= 1'b0;
            end

            MEASURE_EN <= (regs[ADDR_POWER_CTL][1:0] == 2'b10);
        end
    end

    assign MISO = miso_q & (state == ST_RD_DATA);

endmodule

// File: tb/tb_spi_accel_responder.sv
// Scoreboard bench for spi_accel_responder: expected read bytes and config writes
// are queued as stimulus is issued and popped as the DUT produces them.
module tb_spi_accel_responder;

    localparam int HP = 80;  // SPI half period, 10 CLKs

    logic       CLK = 1'b0;
    logic       RESET, CS, SCLK, MOSI, MISO;
    logic [7:0] SAMPLE_X, SAMPLE_Y, SAMPLE_Z;
    logic       SAMPLE_VALID;
    logic       CFG_WR;
    logic [5:0] CFG_ADDR;
    logic [7:0] CFG_DATA;
    logic       MEASURE_EN;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  exp_rd [$];
    logic [13:0] exp_wr [$];
    logic        prev_wr = 1'b0;
    logic [13:0] wr_e;

    spi_accel_responder #(.SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET(RESET), .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .SAMPLE_X(SAMPLE_X), .SAMPLE_Y(SAMPLE_Y), .SAMPLE_Z(SAMPLE_Z),
        .SAMPLE_VALID(SAMPLE_VALID), .CFG_WR(CFG_WR), .CFG_ADDR(CFG_ADDR),
        .CFG_DATA(CFG_DATA), .MEASURE_EN(MEASURE_EN)
    );

    always #4 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Config-write monitor: every CFG_WR pulse must match the next queued write and last one CLK.
    always @(negedge CLK) begin
        if (CFG_WR) begin
            if (exp_wr.size() == 0) begin
                check_val("cfg_wr_unexpected", {31'd0, CFG_WR}, 32'd0);
            end else begin
                wr_e = exp_wr.pop_front();
                check_val("cfg_wr", {18'd0, CFG_ADDR, CFG_DATA}, {18'd0, wr_e});
            end
            check_val("cfg_wr_width", {31'd0, prev_wr}, 32'd0);
        end
        prev_wr = CFG_WR;
    end

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = tx[7-i];
            #HP;
            SCLK = 1'b1;
            rx = {rx[6:0], MISO};
            #HP;
            SCLK = 1'b0;
        end
    endtask

    task automatic cs_begin();
        CS = 1'b0;
        #HP;
    endtask

    task automatic cs_end();
        #HP;
        CS   = 1'b1;
        MOSI = 1'b0;
        #(4*HP);
    endtask

    task automatic spi_read(input logic [7:0] addr, input int n);
        logic [7:0] rx, e;
        cs_begin();
        spi_bits(8'h0B, 8, rx);
        spi_bits(addr, 8, rx);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'h00, 8, rx);
            e = exp_rd.pop_front();
            check_val($sformatf("rd@%02h", addr + i[7:0]), {24'd0, rx}, {24'd0, e});
        end
        cs_end();
    endtask

    task automatic spi_write(input logic [7:0] op, input logic [7:0] addr,
                             input logic [23:0] d, input int n);
        logic [7:0] rx;
        cs_begin();
        spi_bits(op, 8, rx);
        spi_bits(addr, 8, rx);
        for (int i = 0; i < n; i++) begin
            spi_bits(d[23-8*i -: 8], 8, rx);
            check_val("miso_quiet", {24'd0, rx}, 32'd0);
        end
        cs_end();
    endtask

    task automatic pulse_sample(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        @(negedge CLK);
        SAMPLE_X = x; SAMPLE_Y = y; SAMPLE_Z = z;
        SAMPLE_VALID = 1'b1;
        @(negedge CLK);
        SAMPLE_VALID = 1'b0;
    endtask

    initial begin
        logic [7:0] rx;
        RESET = 1'b1; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        SAMPLE_X = 8'h00; SAMPLE_Y = 8'h00; SAMPLE_Z = 8'h00; SAMPLE_VALID = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        check_val("rst_miso",    {31'd0, MISO},       32'd0);
        check_val("rst_cfg_wr",  {31'd0, CFG_WR},     32'd0);
        check_val("rst_cfg_adr", {26'd0, CFG_ADDR},   32'd0);
        check_val("rst_cfg_dat", {24'd0, CFG_DATA},   32'd0);
        check_val("rst_meas",    {31'd0, MEASURE_EN}, 32'd0);
        repeat (10) @(negedge CLK);

        // DEVID and the ID burst
        exp_rd.push_back(8'hAD);
        spi_read(8'h00, 1);
        exp_rd.push_back(8'hAD); exp_rd.push_back(8'h1D);
        exp_rd.push_back(8'hF2); exp_rd.push_back(8'h01);
        spi_read(8'h00, 4);

        // Power control write enables measurement
        exp_wr.push_back({6'h2D, 8'h0A});
        spi_write(8'h0A, 8'h2D, 24'h0A0000, 1);
        check_val("meas_on",       {31'd0, MEASURE_EN}, 32'd1);
        check_val("cfg_addr_hold", {26'd0, CFG_ADDR},   32'h2D);
        check_val("cfg_data_hold", {24'd0, CFG_DATA},   32'h0A);
        exp_rd.push_back(8'h0A);
        spi_read(8'h2D, 1);

        // Read-only target: dropped
        spi_write(8'h0A, 8'h05, 24'h550000, 1);
        exp_rd.push_back(8'h00);
        spi_read(8'h05, 1);

        // Samples with CS high land immediately; mid-burst samples are deferred
        pulse_sample(8'h34, 8'h56, 8'h78);
        exp_rd.push_back(8'h34); exp_rd.push_back(8'h56); exp_rd.push_back(8'h78);
        spi_read(8'h09, 3);
        cs_begin();
        spi_bits(8'h0B, 8, rx);
        spi_bits(8'h09, 8, rx);
        pulse_sample(8'hAA, 8'hBB, 8'hCC);
        pulse_sample(8'h12, 8'h9A, 8'hBC);
        exp_rd.push_back(8'h34); exp_rd.push_back(8'h56); exp_rd.push_back(8'h78);
        for (int i = 0; i < 3; i++) begin
            spi_bits(8'h00, 8, rx);
            check_val($sformatf("burst_old%0d", i), {24'd0, rx}, {24'd0, exp_rd.pop_front()});
        end
        cs_end();
        exp_rd.push_back(8'h12); exp_rd.push_back(8'h9A); exp_rd.push_back(8'hBC);
        spi_read(8'h09, 3);

        // Partial data byte aborted by CS rise
        cs_begin();
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'h20, 8, rx);
        spi_bits(8'hFF, 4, rx);
        cs_end();
        exp_rd.push_back(8'h00);
        spi_read(8'h20, 1);

        // Burst write across the top of the writable window
        exp_wr.push_back({6'h3E, 8'h11});
        exp_wr.push_back({6'h3F, 8'h22});
        spi_write(8'h0A, 8'h3E, 24'h112233, 3);
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h00);
        spi_read(8'h3E, 3);

        // Unknown opcode is ignored
        spi_write(8'h03, 8'h2D, 24'hFF0000, 1);
        exp_rd.push_back(8'h0A);
        spi_read(8'h2D, 1);

        // Reset mid-read while CS stays low
        cs_begin();
        spi_bits(8'h0B, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 3, rx);
        check_val("pre_reset_bits", {29'd0, rx[2:0]}, 32'h5);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        spi_bits(8'h00, 5, rx);
        check_val("post_reset_tail", {24'd0, rx}, 32'd0);
        spi_bits(8'h0B, 8, rx);
        check_val("post_reset_byte", {24'd0, rx}, 32'd0);
        check_val("post_reset_meas", {31'd0, MEASURE_EN}, 32'd0);
        cs_end();
        exp_rd.push_back(8'hAD);
        spi_read(8'h00, 1);
        exp_rd.push_back(8'h00); exp_rd.push_back(8'h00);
        spi_read(8'h2C, 2);

        // MEASURE_EN follows POWER_CTL[1:0]
        exp_wr.push_back({6'h2D, 8'h0A});
        spi_write(8'h0A, 8'h2D, 24'h0A0000, 1);
        check_val("meas_on2", {31'd0, MEASURE_EN}, 32'd1);
        exp_wr.push_back({6'h2D, 8'h03});
        spi_write(8'h0A, 8'h2D, 24'h030000, 1);
        check_val("meas_off", {31'd0, MEASURE_EN}, 32'd0);

        repeat (20) @(negedge CLK);
        check_val("wr_left",  exp_wr.size(), 32'd0);
        check_val("rd_left",  exp_rd.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
